// File: rtl/effects_chain_if.sv
// effects_chain_if: sample stream, control and status bundle for effects_chain; NOISE_GATE_EN adds gate_threshold
interface effects_chain_if #(parameter int DATA_W = 16, parameter int GAIN_W = 11);
  logic in_valid, in_ready, bypass, out_valid, out_ready, out_clipped;
  logic [DATA_W-1:0] in_sample, out_sample;
  logic [GAIN_W-1:0] gain;
  logic [DATA_W-2:0] clip_level;
  logic [15:0] clip_count;
`ifdef NOISE_GATE_EN
  logic [DATA_W-2:0] gate_threshold;
  modport master(output in_valid, in_sample, gain, clip_level, bypass, out_ready, gate_threshold,
                 input in_ready, out_valid, out_sample, out_clipped, clip_count);
  modport slave(input in_valid, in_sample, gain, clip_level, bypass, out_ready, gate_threshold,
                output in_ready, out_valid, out_sample, out_clipped, clip_count);
`else
  modport master(output in_valid, in_sample, gain, clip_level, bypass, out_ready,
                 input in_ready, out_valid, out_sample, out_clipped, clip_count);
  modport slave(input in_valid, in_sample, gain, clip_level, bypass, out_ready,
                output in_ready, out_valid, out_sample, out_clipped, clip_count);
`endif
endinterface

// File: rtl/effects_chain.sv
// effects_chain: 3-stage gain/saturate/clip stream pipeline; NOISE_GATE_EN adds a hold-off noise gate
module effects_chain #(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 11,
  parameter int GAIN_FRAC = 8,
  parameter int GATE_HOLD = 256
) (
  input logic clk,
  input logic rst,
  effects_chain_if.slave s
);
  localparam int PW = DATA_W + GAIN_W + 1;
  localparam int QW = PW - GAIN_FRAC;
  localparam logic signed [QW-1:0] MAXV = QW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [QW-1:0] MINV = ~MAXV;
  logic adv;
  logic s1_valid, s1_bypass, s2_valid, s2_bypass, s2_sat, sat, hi, lo, s3_clip, o_clipped;
  logic [DATA_W-1:0] s1_sample, s2_val, s2_next, s3_next, o_sample;
  logic [GAIN_W-1:0] s1_gain;
  logic [DATA_W-2:0] s1_clip, s2_clip;
  logic signed [PW-1:0] p;
  logic signed [QW-1:0] q;
  logic signed [DATA_W-1:0] v, cl_pos, cl_neg, y;
  assign adv = !s.out_valid || s.out_ready;
  assign s.in_ready = adv;
  // S2 arithmetic: signed*unsigned product, floor shift, saturate to sample range
  always_comb begin
    p = PW'($signed(s1_sample)) * $signed(PW'({1'b0, s1_gain}));
    q = QW'(p >>> GAIN_FRAC);
    sat = !s1_bypass && (q > MAXV || q < MINV);
    s2_next = s1_bypass ? s1_sample : q > MAXV ? MAXV[DATA_W-1:0] : q < MINV ? MINV[DATA_W-1:0] : q[DATA_W-1:0];
  end
  // S3 symmetric clip; full-scale clip_level leaves the saturated negative rail untouched
  always_comb begin
    v = $signed(s2_val);
    cl_pos = $signed({1'b0, s2_clip});
    cl_neg = -cl_pos;
    hi = v > cl_pos;
    lo = !(&s2_clip) && v < cl_neg;
    y = hi ? cl_pos : lo ? cl_neg : v;
    s3_clip = !s2_bypass && (s2_sat || hi || lo);
    s3_next = s2_bypass ? s2_val : y;
  end
`ifdef NOISE_GATE_EN
  logic [15:0] gate_cnt;
  logic [DATA_W-1:0] mag;
  logic quiet, gated;
  // gate closes once GATE_HOLD quiet samples have already passed; a loud sample reopens at once
  always_comb begin
    mag = y[DATA_W-1] ? -y : y;
    quiet = mag < {1'b0, s.gate_threshold};
    gated = !s2_bypass && quiet && gate_cnt >= 16'(GATE_HOLD);
    o_sample = gated ? '0 : s3_next;
    o_clipped = !gated && s3_clip;
  end
  // quiet-run counter, updated only for processed samples leaving S3
  always_ff @(posedge clk)
    if (rst) gate_cnt <= '0;
    else if (adv && s2_valid && !s2_bypass) gate_cnt <= !quiet ? '0 : gate_cnt == 16'(GATE_HOLD) ? gate_cnt : gate_cnt + 16'd1;
`else
  // no gate: S3 result goes straight to the output register
  always_comb begin
    o_sample = s3_next;
    o_clipped = s3_clip;
  end
`endif
  // pipeline registers; every stage shifts together on adv
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0; s1_bypass <= 1'b0; s1_sample <= '0; s1_gain <= '0; s1_clip <= '0;
      s2_valid <= 1'b0; s2_bypass <= 1'b0; s2_sat <= 1'b0; s2_val <= '0; s2_clip <= '0;
      s.out_valid <= 1'b0; s.out_sample <= '0; s.out_clipped <= 1'b0;
    end else if (adv) begin
      s1_valid <= s.in_valid; s1_bypass <= s.bypass; s1_sample <= s.in_sample; s1_gain <= s.gain; s1_clip <= s.clip_level;
      s2_valid <= s1_valid; s2_bypass <= s1_bypass; s2_sat <= sat; s2_val <= s2_next; s2_clip <= s1_clip;
      s.out_valid <= s2_valid;
      if (s2_valid) begin
        s.out_sample <= o_sample;
        s.out_clipped <= o_clipped;
      end
    end
  end
  // saturating count of delivered clipped samples
  always_ff @(posedge clk)
    if (rst) s.clip_count <= '0;
    else if (s.out_valid && s.out_ready && s.out_clipped && !(&s.clip_count)) s.clip_count <= s.clip_count + 16'd1;
endmodule
